// File: rtl/pipe_stage_hs_if.sv
// Handshake and payload bundle for pipe_stage_hs.
// The driver side takes master and the stage takes slave.
interface pipe_stage_hs_if #(
   parameter int REG_W = 32,
   parameter int WD_W  = 5,
   parameter int OP_W  = 8,
   parameter int SEL_W = 3,
   parameter int CNT_W = 16
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [OP_W-1:0]  in_aluop;
   logic [SEL_W-1:0] in_alusel;
   logic [REG_W-1:0] in_reg1;
   logic [REG_W-1:0] in_reg2;
   logic [WD_W-1:0]  in_wd;
   logic             in_wreg;
   logic             out_valid;
   logic             out_ready;
   logic [OP_W-1:0]  out_aluop;
   logic [SEL_W-1:0] out_alusel;
   logic [REG_W-1:0] out_reg1;
   logic [REG_W-1:0] out_reg2;
   logic [WD_W-1:0]  out_wd;
   logic             out_wreg;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output flush, in_valid, in_aluop, in_alusel, in_reg1, in_reg2, in_wd, in_wreg, out_ready,
      input  in_ready, out_valid, out_aluop, out_alusel, out_reg1, out_reg2, out_wd, out_wreg,
             stall_cnt
   );

   modport slave (
      input  flush, in_valid, in_aluop, in_alusel, in_reg1, in_reg2, in_wd, in_wreg, out_ready,
      output in_ready, out_valid, out_aluop, out_alusel, out_reg1, out_reg2, out_wd, out_wreg,
             stall_cnt
   );
endinterface

// File: rtl/pipe_stage_hs.sv
// Pipeline register stage with a 2-entry skid buffer, flush and a saturating
// backpressure cycle counter.
module pipe_stage_hs #(
   parameter int REG_W = 32,
   parameter int WD_W  = 5,
   parameter int OP_W  = 8,
   parameter int SEL_W = 3,
   parameter int CNT_W = 16
) (
   input logic           clk,
   input logic           rst,
   pipe_stage_hs_if.slave hs
);
   localparam int PW = OP_W + SEL_W + 2 * REG_W + WD_W + 1;

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]       state_q, state_n;
   logic [PW-1:0]    main_q, main_n;
   logic [PW-1:0]    skid_q, skid_n;
   logic [PW-1:0]    in_pl;
   logic             in_ready_q;
   logic [CNT_W-1:0] stall_q;
   logic             out_valid;
   logic             in_xfer;
   logic             out_xfer;

   assign in_pl     = {hs.in_aluop, hs.in_alusel, hs.in_reg1, hs.in_reg2, hs.in_wd, hs.in_wreg};
   assign out_valid = (state_q != EMPTY);
   assign in_xfer   = hs.in_valid & in_ready_q;
   assign out_xfer  = out_valid & hs.out_ready;

   // main is zeroed whenever it is vacated, so the outputs show NOP while empty
   assign {hs.out_aluop, hs.out_alusel, hs.out_reg1, hs.out_reg2, hs.out_wd, hs.out_wreg} = main_q;
   assign hs.out_valid = out_valid;
   assign hs.in_ready  = in_ready_q;
   assign hs.stall_cnt = stall_q;

   always_comb begin
      state_n = state_q;
      main_n  = main_q;
      skid_n  = skid_q;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               main_n  = in_pl;
               state_n = ONE;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               main_n = in_pl;
            end else if (in_xfer) begin
               skid_n  = in_pl;
               state_n = FULL;
            end else if (out_xfer) begin
               main_n  = '0;
               state_n = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               main_n  = skid_q;
               skid_n  = '0;
               state_n = ONE;
            end
         end
         default: begin
            state_n = EMPTY;
            main_n  = '0;
            skid_n  = '0;
         end
      endcase
      if (hs.flush) begin
         state_n = EMPTY;
         main_n  = '0;
         skid_n  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
         stall_q    <= '0;
      end else begin
         state_q    <= state_n;
         main_q     <= main_n;
         skid_q     <= skid_n;
         in_ready_q <= (state_n != FULL);
         if (out_valid && !hs.out_ready && (stall_q != '1))
            stall_q <= stall_q + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: vector table for streaming, skid, flush,
// plus hand sequences for stall counting, saturation and reset while full.
module tb_pipe_stage_hs;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pipe_stage_hs_if #(.REG_W(32), .WD_W(5), .OP_W(8), .SEL_W(3), .CNT_W(16)) hif ();
   pipe_stage_hs_if #(.REG_W(32), .WD_W(5), .OP_W(8), .SEL_W(3), .CNT_W(2))  hif2 ();

   pipe_stage_hs #(.REG_W(32), .WD_W(5), .OP_W(8), .SEL_W(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .hs(hif)
   );
   pipe_stage_hs #(.REG_W(32), .WD_W(5), .OP_W(8), .SEL_W(3), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .hs(hif2)
   );

   typedef struct {
      logic        iv;
      logic        fl;
      logic        ordy;
      logic [31:0] reg1;
      logic [4:0]  wd;
      logic        wreg;
      logic        e_ov;
      logic [31:0] e_reg1;
      logic [4:0]  e_wd;
      logic        e_wreg;
      logic        e_ir;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic iv, input logic fl, input logic ordy, input logic [31:0] reg1,
                      input logic [4:0] wd, input logic wreg, input logic e_ov,
                      input logic [31:0] e_reg1, input logic [4:0] e_wd, input logic e_wreg,
                      input logic e_ir);
      vec_t v;
      v.iv = iv; v.fl = fl; v.ordy = ordy; v.reg1 = reg1; v.wd = wd; v.wreg = wreg;
      v.e_ov = e_ov; v.e_reg1 = e_reg1; v.e_wd = e_wd; v.e_wreg = e_wreg; v.e_ir = e_ir;
      vq.push_back(v);
   endtask

   // aluop/alusel/reg2 are derived from reg1 so every payload field is traceable
   task automatic drive(input logic iv, input logic fl, input logic ordy, input logic [31:0] reg1,
                        input logic [4:0] wd, input logic wreg);
      hif.in_valid  = iv;
      hif.flush     = fl;
      hif.out_ready = ordy;
      hif.in_reg1   = reg1;
      hif.in_reg2   = ~reg1;
      hif.in_aluop  = reg1[7:0];
      hif.in_alusel = reg1[2:0];
      hif.in_wd     = wd;
      hif.in_wreg   = wreg;
   endtask

   task automatic check_out(input string tag, input logic e_ov, input logic [31:0] e_reg1,
                            input logic [4:0] e_wd, input logic e_wreg, input logic e_ir);
      logic [31:0] r2;
      r2 = e_ov ? ~e_reg1 : 32'h0;
      chk({tag, ".out_valid"},  hif.out_valid,  e_ov);
      chk({tag, ".out_reg1"},   hif.out_reg1,   e_reg1);
      chk({tag, ".out_reg2"},   hif.out_reg2,   r2);
      chk({tag, ".out_aluop"},  hif.out_aluop,  e_reg1[7:0]);
      chk({tag, ".out_alusel"}, hif.out_alusel, e_reg1[2:0]);
      chk({tag, ".out_wd"},     hif.out_wd,     e_wd);
      chk({tag, ".out_wreg"},   hif.out_wreg,   e_wreg);
      chk({tag, ".in_ready"},   hif.in_ready,   e_ir);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
      hif2.flush = 1'b0; hif2.in_valid = 1'b0; hif2.out_ready = 1'b0;
      hif2.in_reg1 = '0; hif2.in_reg2 = '0; hif2.in_aluop = '0; hif2.in_alusel = '0;
      hif2.in_wd = '0; hif2.in_wreg = 1'b0;
      repeat (2) tick();
      check_out("reset", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
      chk("reset.stall_cnt", hif.stall_cnt, 16'd0);
      rst = 1'b0;

      // iv fl ordy reg1 wd wreg | ov reg1 wd wreg ir
      add(1, 0, 1, 32'h11, 5'd3, 1, 1, 32'h11, 5'd3, 1, 1);
      add(0, 0, 1, 32'h0,  5'd0, 0, 0, 32'h0,  5'd0, 0, 1);
      for (int k = 1; k <= 8; k++)
         add(1, 0, 1, 32'(k), 5'(k), k[0], 1, 32'(k), 5'(k), k[0], 1);
      add(0, 0, 1, 32'h0,  5'd0, 0, 0, 32'h0,  5'd0, 0, 1);
      // A then B under backpressure, then drain A, B
      add(1, 0, 0, 32'hA0, 5'd10, 1, 1, 32'hA0, 5'd10, 1, 1);
      add(1, 0, 0, 32'hB0, 5'd11, 0, 1, 32'hA0, 5'd10, 1, 0);
      add(0, 0, 0, 32'h0,  5'd0,  0, 1, 32'hA0, 5'd10, 1, 0);
      add(0, 0, 1, 32'h0,  5'd0,  0, 1, 32'hB0, 5'd11, 0, 1);
      add(0, 0, 1, 32'h0,  5'd0,  0, 0, 32'h0,  5'd0,  0, 1);
      // fill to FULL, then flush with C offered
      add(1, 0, 0, 32'hD0, 5'd13, 1, 1, 32'hD0, 5'd13, 1, 1);
      add(1, 0, 0, 32'hE0, 5'd14, 1, 1, 32'hD0, 5'd13, 1, 0);
      add(1, 1, 1, 32'hC0, 5'd12, 1, 0, 32'h0,  5'd0,  0, 1);
      add(0, 0, 1, 32'h0,  5'd0,  0, 0, 32'h0,  5'd0,  0, 1);
      // flush in ONE while in_ready=1: the offered entry must be discarded
      add(1, 0, 0, 32'h55, 5'd5,  1, 1, 32'h55, 5'd5,  1, 1);
      add(1, 1, 1, 32'h77, 5'd7,  1, 0, 32'h0,  5'd0,  0, 1);
      add(0, 0, 1, 32'h0,  5'd0,  0, 0, 32'h0,  5'd0,  0, 1);

      foreach (vq[i]) begin
         drive(vq[i].iv, vq[i].fl, vq[i].ordy, vq[i].reg1, vq[i].wd, vq[i].wreg);
         tick();
         check_out($sformatf("vec%0d", i), vq[i].e_ov, vq[i].e_reg1, vq[i].e_wd,
                   vq[i].e_wreg, vq[i].e_ir);
      end

      // stall counting and saturation on both instances
      drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 32'h31, 5'd1, 1'b1);
      hif2.in_valid = 1'b1; hif2.in_reg1 = 32'h31; hif2.out_ready = 1'b0;
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
      hif2.in_valid = 1'b0;
      repeat (5) tick();
      chk("stall5.cnt16", hif.stall_cnt, 16'd5);
      chk("stall5.cnt2", hif2.stall_cnt, 2'd3);
      tick();
      chk("stall6.cnt16", hif.stall_cnt, 16'd6);
      chk("stall6.cnt2_sat", hif2.stall_cnt, 2'd3);
      chk("stall6.hold_reg1", hif.out_reg1, 32'h31);
      chk("stall6.hold_valid", hif.out_valid, 1'b1);

      // reset while FULL
      drive(1'b1, 1'b0, 1'b0, 32'h32, 5'd2, 1'b0);
      tick();
      chk("full.in_ready", hif.in_ready, 1'b0);
      chk("full.out_reg1", hif.out_reg1, 32'h31);
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 32'h33, 5'd3, 1'b1);
      tick();
      chk("rstfull.out_valid", hif.out_valid, 1'b0);
      chk("rstfull.stall_cnt", hif.stall_cnt, 16'd0);
      chk("rstfull.in_ready", hif.in_ready, 1'b1);
      chk("rstfull.out_reg1", hif.out_reg1, 32'h0);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 32'h0, 5'd0, 1'b0);
      tick();
      chk("postrst.out_valid", hif.out_valid, 1'b0);
      tick();
      chk("postrst2.out_valid", hif.out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_stage_hs.md
PIPE_STAGE_HS -- requirements
Module: pipe_stage_hs

Interface
REQ-001 The block SHALL have parameter REG_W, default 32, meaning the operand width of reg1/reg2.
REQ-002 The block SHALL have parameter WD_W, default 5, meaning the destination register address width.
REQ-003 The block SHALL have parameter OP_W, default 8, meaning the ALU op code width.
REQ-004 The block SHALL have parameter SEL_W, default 3, meaning the ALU result-select width.
REQ-005 The block SHALL have parameter CNT_W, default 16, meaning the stall counter width.
REQ-006 Port clk SHALL be an input of width 1 and is the clock; all state changes on its rising edge.
REQ-007 Port rst SHALL be an input of width 1 and is the reset: synchronous, active-high.
REQ-008 Port flush SHALL be an input of width 1 that discards all held and incoming entries.
REQ-009 Port in_valid SHALL be an input of width 1 meaning an upstream entry is present.
REQ-010 Port in_ready SHALL be an output of width 1, registered, meaning the block accepts an entry this cycle.
REQ-011 Ports in_aluop (input, OP_W), in_alusel (input, SEL_W), in_reg1 (input, REG_W), in_reg2 (input, REG_W), in_wd (input, WD_W) and in_wreg (input, 1) SHALL carry the entry payload.
REQ-012 Port out_valid SHALL be an output of width 1 meaning an output entry is present.
REQ-013 Port out_ready SHALL be an input of width 1 meaning downstream consumes the entry.
REQ-014 Ports out_aluop, out_alusel, out_reg1, out_reg2, out_wd and out_wreg SHALL be outputs, with widths matching the corresponding in_* ports, carrying the registered payload.
REQ-015 Port stall_cnt SHALL be an output of width CNT_W counting backpressure cycles.

Function
REQ-016 Input transfer SHALL occur when in_valid and in_ready are both 1; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-017 Storage SHALL be a 2-entry skid buffer (main, skid) with states EMPTY, ONE and FULL.
REQ-018 From EMPTY, an input transfer SHALL move the block to ONE, and the entry SHALL appear on the outputs the next cycle (latency 1).
REQ-019 In ONE with an input and an output transfer in the same cycle, the new entry SHALL load main and the state SHALL stay ONE (throughput 1/cycle).
REQ-020 In ONE with an input transfer and no output transfer, the new entry SHALL load skid, the state SHALL go to FULL, and in_ready SHALL be 0 the next cycle.
REQ-021 In ONE with an output transfer and no input transfer, the state SHALL go to EMPTY.
REQ-022 In FULL with an output transfer, skid SHALL move to main, the state SHALL go to ONE, and in_ready SHALL be 1 the next cycle.
REQ-023 In FULL, no input transfer SHALL occur (in_ready=0).
REQ-024 Order SHALL be preserved: entries leave in acceptance order, with none lost or duplicated.
REQ-025 The outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 While out_valid=0, the outputs SHALL present NOP values: aluop 0, alusel 0, reg1/reg2 0, wd 0, wreg 0.
REQ-027 in_ready SHALL equal (next state != FULL), registered.
REQ-028 Flush SHALL clear the state to EMPTY the next cycle and drive the outputs to NOP values.
REQ-029 On flush, same-cycle in_valid SHALL be discarded and out_ready SHALL be ignored.
REQ-030 in_ready SHALL be 1 in the cycle after a flush.
REQ-031 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0.
REQ-032 stall_cnt SHALL saturate at 2^CNT_W-1 and SHALL be unaffected by flush.

Reset
REQ-033 rst SHALL take priority over flush and all handshakes.
REQ-034 During and after rst, the block SHALL be in state EMPTY with out_valid=0, outputs at NOP values, in_ready=1 and stall_cnt=0.
REQ-035 rst asserted mid-operation while FULL SHALL drop both entries, with no entry emitted after rst deasserts.

Verification
REQ-036 The bench SHALL cover: after rst, in_valid=1 with reg1=0x11, wd=3, wreg=1, out_ready=1 -> the next cycle out_valid=1, out_reg1=0x11, out_wd=3.
REQ-037 The bench SHALL cover: a streaming burst of 8 entries (reg1=1..8) with out_ready held 1 -> 8 consecutive outputs 1..8 and in_ready constantly 1.
REQ-038 The bench SHALL cover: out_ready=0 with entries A then B offered -> A on outputs, B in skid, in_ready=0; on out_ready=1 the outputs are A, then B.
REQ-039 The bench SHALL cover: flush while FULL, together with in_valid=1 carrying C -> the next cycle out_valid=0, NOP outputs, in_ready=1, and C never appears.
REQ-040 The bench SHALL cover: out_valid=1 with out_ready=0 for 5 cycles -> stall_cnt=5; with CNT_W=2, holding for 6 cycles -> stall_cnt=3.
REQ-041 The bench SHALL cover: rst asserted while FULL -> the next cycle out_valid=0, stall_cnt=0, in_ready=1.
